// File: rtl/cmt_prog_pkg.sv
// Shared types and constants for the DCM_CLKGEN M/D programming sequencer.
package cmt_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_D    = 3'd1,
        ST_GAP_D     = 3'd2,
        ST_LOAD_M    = 3'd3,
        ST_GAP_M     = 3'd4,
        ST_GO        = 3'd5,
        ST_WAIT_DONE = 3'd6
    } state_t;

    localparam logic [1:0] CMD_LOAD_D  = 2'b01;
    localparam logic [1:0] CMD_LOAD_M  = 2'b11;
    localparam int         LOAD_BITS   = 10;
    localparam int         GAP_PERIODS = 2;

    // Serial frame, bit 0 is sent first: command bit0, command bit1, then value LSB first.
    function automatic logic [9:0] make_frame(input logic [1:0] cmd, input logic [7:0] val);
        return {val, cmd};
    endfunction

endpackage

// File: rtl/cmt_prog_clkdiv.sv
// PROGCLK generator: low for the first half of each period, high for the second,
// with a strobe on the CLK edge where PROGCLK falls (period boundary).
module cmt_prog_clkdiv #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic halt,
    output logic progclk,
    output logic fall_stb
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          progclk_r;

    // Next divide count; parked at zero whenever the sequencer is idle or about to be.
    always_comb begin
        cnt_s = '0;
        if (!run || halt) begin
            cnt_s = '0;
        end else if (cnt_r == LAST) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CW'(1);
        end
    end

    assign fall_stb = run && (cnt_r == LAST);

    // Divide counter and registered PROGCLK.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r     <= '0;
            progclk_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            progclk_r <= (cnt_s >= HALF);
        end
    end

    assign progclk = progclk_r;

endmodule

// File: rtl/cmt_prog_ctrl.sv
// DCM_CLKGEN run-time M/D reprogramming sequencer.
// Optional PROGDONE timeout is built when CMT_PROG_TIMEOUT_EN is defined.
module cmt_prog_ctrl
    import cmt_prog_pkg::*;
#(
    parameter int PROGCLK_DIV    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       REQ,
    input  logic [7:0] MULT_M1,
    input  logic [7:0] DIV_D1,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic       TIMEOUT,
    output logic       PROGCLK,
    output logic       PROGEN,
    output logic       PROGDATA,
    input  logic       PROGDONE
);

    localparam logic [3:0] LAST_BIT = 4'(LOAD_BITS - 1);
    localparam logic [3:0] LAST_GAP = 4'(GAP_PERIODS - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [9:0]  shift_r, shift_s;
    logic [9:0]  frame_s;
    logic [7:0]  m1_r, m1_s;
    logic        progen_r, progen_s;
    logic        progdata_r, progdata_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        error_r, error_s;
    logic        err_pend_r, err_pend_s;
    logic        fin_r, fin_s;
    logic        sync1_r, sync2_r, prev_r;
    logic        rise_s, accept_s, fall_s, run_s, halt_s;

`ifdef CMT_PROG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic             timeout_r, timeout_s;
`endif

    // fin_r blocks acceptance in the cycle where DONE/ERROR ends the previous request.
    assign accept_s = REQ && !busy_r && !fin_r;
    assign rise_s   = sync2_r && !prev_r;
    assign run_s    = (state_r != ST_IDLE);
    assign halt_s   = (state_s == ST_IDLE);

    cmt_prog_clkdiv #(.DIV(PROGCLK_DIV)) u_clkdiv (
        .clk      (CLK),
        .reset_n  (RESET_N),
        .run      (run_s),
        .halt     (halt_s),
        .progclk  (PROGCLK),
        .fall_stb (fall_s)
    );

    // Sequencer next-state and output decode; serial outputs change only on PROGCLK fall.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        shift_s    = shift_r;
        m1_s       = m1_r;
        progen_s   = progen_r;
        progdata_s = progdata_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        fin_s      = 1'b0;
        error_s    = error_r;
        err_pend_s = err_pend_r;
        frame_s    = 10'd0;
`ifdef CMT_PROG_TIMEOUT_EN
        timeout_s  = timeout_r;
        tmo_cnt_s  = tmo_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                progen_s   = 1'b0;
                progdata_s = 1'b0;
                if (err_pend_r) begin
                    error_s    = 1'b1;
                    busy_s     = 1'b0;
                    err_pend_s = 1'b0;
                    fin_s      = 1'b1;
                end else if (accept_s) begin
                    error_s = 1'b0;
                    busy_s  = 1'b1;
                    m1_s    = MULT_M1;
`ifdef CMT_PROG_TIMEOUT_EN
                    timeout_s = 1'b0;
`endif
                    if (MULT_M1 == 8'd0) begin
                        err_pend_s = 1'b1;
                    end else begin
                        frame_s    = make_frame(CMD_LOAD_D, DIV_D1);
                        state_s    = ST_LOAD_D;
                        cnt_s      = 4'd0;
                        progen_s   = 1'b1;
                        progdata_s = frame_s[0];
                        shift_s    = {1'b0, frame_s[9:1]};
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_LOAD_D, ST_LOAD_M: begin
                if (fall_s) begin
                    if (cnt_r == LAST_BIT) begin
                        state_s    = (state_r == ST_LOAD_D) ? ST_GAP_D : ST_GAP_M;
                        cnt_s      = 4'd0;
                        progen_s   = 1'b0;
                        progdata_s = 1'b0;
                    end else begin
                        cnt_s      = cnt_r + 4'd1;
                        progdata_s = shift_r[0];
                        shift_s    = {1'b0, shift_r[9:1]};
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_GAP_D, ST_GAP_M: begin
                if (fall_s) begin
                    if (cnt_r == LAST_GAP) begin
                        cnt_s    = 4'd0;
                        progen_s = 1'b1;
                        if (state_r == ST_GAP_D) begin
                            frame_s    = make_frame(CMD_LOAD_M, m1_r);
                            state_s    = ST_LOAD_M;
                            progdata_s = frame_s[0];
                            shift_s    = {1'b0, frame_s[9:1]};
                        end else begin
                            state_s    = ST_GO;
                            progdata_s = 1'b0;
                        end
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_GO: begin
                if (fall_s) begin
                    state_s    = ST_WAIT_DONE;
                    progen_s   = 1'b0;
                    progdata_s = 1'b0;
`ifdef CMT_PROG_TIMEOUT_EN
                    tmo_cnt_s  = '0;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT_DONE: begin
                if (rise_s) begin
                    done_s  = 1'b1;
                    fin_s   = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
`ifdef CMT_PROG_TIMEOUT_EN
                end else if (tmo_cnt_r == TMO_LAST) begin
                    error_s   = 1'b1;
                    timeout_s = 1'b1;
                    fin_s     = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
`else
                end else begin
                    state_s = state_r;
                end
`endif
            end
            default: begin
                state_s    = ST_IDLE;
                busy_s     = 1'b0;
                progen_s   = 1'b0;
                progdata_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            shift_r    <= 10'd0;
            m1_r       <= 8'd0;
            progen_r   <= 1'b0;
            progdata_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_pend_r <= 1'b0;
            fin_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            shift_r    <= shift_s;
            m1_r       <= m1_s;
            progen_r   <= progen_s;
            progdata_r <= progdata_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
            err_pend_r <= err_pend_s;
            fin_r      <= fin_s;
        end
    end

    // PROGDONE two-flop synchronizer plus edge-detect history.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= PROGDONE;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

`ifdef CMT_PROG_TIMEOUT_EN
    // Timeout counter and flag.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            tmo_cnt_r <= '0;
            timeout_r <= 1'b0;
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
            timeout_r <= timeout_s;
        end
    end
    assign TIMEOUT = timeout_r;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign ERROR    = error_r;
    assign PROGEN   = progen_r;
    assign PROGDATA = progdata_r;

endmodule

// File: doc/cmt_prog_ctrl.md
# cmt_prog_ctrl

Sequencer that reprograms the M/D ratio of a Spartan-6 DCM_CLKGEN at run time through its serial PROGCLK/PROGEN/PROGDATA port. It sits beside the clock management tile, takes a single multiply/divide request from the host-command logic, generates the programming clock and serial bit stream, waits for PROGDONE, and reports completion or error. One request is in flight at a time.

## Interface
- PROGCLK_DIV, 4: CLK cycles per PROGCLK period; even, ≥2.
- TIMEOUT_CYCLES, 65535: CLK cycles allowed from GO to synchronized PROGDONE; used only with the timeout feature.
- CLK  in  1  system clock; sole clock of the block.
- RESET_N  in  1  synchronous, active-low reset.
- REQ  in  1  request; accepted on a CLK edge where REQ=1 and BUSY=0.
- MULT_M1  in  8  M−1, where M must be in 2..256; sampled on acceptance.
- DIV_D1  in  8  D−1, where D is in 1..256; sampled on acceptance.
- BUSY  out  1  high from the acceptance cycle until DONE or ERROR.
- DONE  out  1  one-cycle pulse on successful completion.
- ERROR  out  1  sticky; cleared by the next accepted REQ.
- TIMEOUT  out  1  sticky; qualifies ERROR; cleared by the next accepted REQ.
- PROGCLK  out  1  registered programming clock to DCM_CLKGEN.PROGCLK.
- PROGEN  out  1  to DCM_CLKGEN.PROGEN.
- PROGDATA  out  1  to DCM_CLKGEN.PROGDATA.
- PROGDONE  in  1  from DCM_CLKGEN; two-flop synchronized internally.

## Operation
- Reset values: BUSY=0, DONE=0, ERROR=0, TIMEOUT=0, PROGCLK=0, PROGEN=0, PROGDATA=0. The state machine is forced to IDLE, including in mid-sequence. PROGEN drops in the same cycle. The DCM keeps whatever it had latched.
- Acceptance with MULT_M1=0 (M=1) is illegal: ERROR=1 one cycle later, BUSY deasserts, and PROGEN stays low throughout.
- States: IDLE → LOAD_D → GAP_D → LOAD_M → GAP_M → GO → WAIT_DONE → IDLE.
- LOAD_D: 10 bits with PROGEN=1. Command bits are 1, 0. Then DIV_D1[0..7], LSB first.
- GAP_D and GAP_M: 2 PROGCLK periods each, with PROGEN=0 and PROGDATA=0.
- LOAD_M: 10 bits with PROGEN=1. Command bits are 1, 1. Then MULT_M1[0..7], LSB first.
- GO: 1 bit with PROGEN=1 and PROGDATA=0.
- WAIT_DONE: PROGEN=0. A rising edge of synchronized PROGDONE pulses DONE and clears BUSY.
- REQ while BUSY=1 is ignored. It is not queued.

## Timing
- PROGCLK: a divide counter runs only while BUSY=1. PROGCLK is low for the first PROGCLK_DIV/2 cycles of each period and high for the remaining PROGCLK_DIV/2. It is held low in IDLE.
- PROGEN and PROGDATA update only on the CLK edge where PROGCLK goes low. The DCM samples them at the PROGCLK rising edge, half a period later.
- The first bit is driven in the cycle after acceptance. That cycle is the start of PROGCLK period 0.
- The bit stream lasts 25 PROGCLK periods: 10 + 2 + 10 + 2 + 1. That is 25·PROGCLK_DIV CLK cycles before WAIT_DONE.
- PROGDONE-to-DONE latency: 3 CLK cycles (2 synchronizer flops plus the edge-detect register).
- DONE and ERROR never assert in the same cycle.
- BUSY falls in the same cycle that DONE or ERROR asserts. A REQ in that same cycle is not accepted; the earliest acceptance is the next cycle.

## Configuration
- CMT_PROG_TIMEOUT_EN defined:
  - A counter starts on entry to WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES without PROGDONE, ERROR=1 and TIMEOUT=1, BUSY clears, and the FSM returns to IDLE.
  - A PROGDONE that arrives later is ignored.
- CMT_PROG_TIMEOUT_EN undefined:
  - WAIT_DONE waits indefinitely.
  - TIMEOUT is tied to 0, and the counter is not built.

## Structure
- Shared package cmt_prog_pkg holds:
  - the state enum;
  - the command constants CMD_LOAD_D=2'b01 and CMD_LOAD_M=2'b11, each sent as bit0 then bit1;
  - the bit counts LOAD_BITS=10 and GAP_PERIODS=2.
- One sub-module, cmt_prog_clkdiv, generates PROGCLK and the one-cycle "falling-edge" strobe from PROGCLK_DIV.
- The top level holds the FSM, a 10-bit shift register, the PROGDONE synchronizer and, optionally, the timeout counter.

## Test plan
- Reset: hold RESET_N=0 for 5 cycles with REQ=1 → all outputs 0, no PROGCLK toggling.
- Program MULT_M1=11, DIV_D1=7 (PROGCLK_DIV=4):
  - At PROGCLK rises with PROGEN=1, the bench samples 1,0,1,1,1,0,0,0,0,0, then 2 periods with PROGEN=0.
  - It then samples 1,1,1,1,0,1,0,0,0,0, 2 periods with PROGEN=0, then GO=0.
  - Pulse PROGDONE 20 cycles later → DONE 3 cycles after the pulse, BUSY falls in the same cycle.
- Second REQ while BUSY → ignored. The stream is unchanged, and exactly one DONE occurs.
- MULT_M1=0 → ERROR=1 one cycle after acceptance, PROGEN never asserts. The next valid REQ clears ERROR.
- With CMT_PROG_TIMEOUT_EN and TIMEOUT_CYCLES=100, PROGDONE held low → ERROR=TIMEOUT=1 exactly 100 cycles after WAIT_DONE entry.
- RESET_N pulsed low during LOAD_M bit 5 → PROGEN=0 and BUSY=0 the next cycle. A fresh REQ then produces a complete, correct 25-period stream.
